// File: rtl/controller_sequencer.sv
// Microcoded-style control sequencer for a SAP-1 class CPU: six-state T ring plus a HALT sink.
// Control outputs decode combinationally from the ring state, the live opcode (T4) and the captured opcode (T5/T6).
module controller_sequencer (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] opcode,
    output logic       pc_increment,
    output logic       pc_output,
    output logic       load_mar,
    output logic       ram_output,
    output logic       load_i,
    output logic       ir_output,
    output logic       load_a,
    output logic       a_output,
    output logic       sub,
    output logic       alu_output,
    output logic       load_b,
    output logic       load_out,
    output logic [5:0] t_state,
    output logic       halted
);

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    typedef enum logic [2:0] {
        S_T1   = 3'd0,
        S_T2   = 3'd1,
        S_T3   = 3'd2,
        S_T4   = 3'd3,
        S_T5   = 3'd4,
        S_T6   = 3'd5,
        S_HALT = 3'd6
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] opcode_q, opcode_d;
    logic       halted_q, halted_d;

    // Next state: everything holds unless enable is high; HALT is only left through reset.
    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        halted_d = halted_q;
        if (enable) begin
            case (state_q)
                S_T1: state_d = S_T2;
                S_T2: state_d = S_T3;
                S_T3: state_d = S_T4;
                S_T4: begin
                    opcode_d = opcode;
                    if (opcode == OP_HLT) begin
                        state_d  = S_HALT;
                        halted_d = 1'b1;
                    end else begin
                        state_d = S_T5;
                    end
                end
                S_T5:    state_d = S_T6;
                S_T6:    state_d = S_T1;
                S_HALT:  state_d = S_HALT;
                default: state_d = S_T1;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_T1;
            opcode_q <= 4'b0000;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            halted_q <= halted_d;
        end
    end

    // Control word decode; a disabled, resetting or halted sequencer drives nothing.
    always_comb begin
        pc_increment = 1'b0;
        pc_output    = 1'b0;
        load_mar     = 1'b0;
        ram_output   = 1'b0;
        load_i       = 1'b0;
        ir_output    = 1'b0;
        load_a       = 1'b0;
        a_output     = 1'b0;
        sub          = 1'b0;
        alu_output   = 1'b0;
        load_b       = 1'b0;
        load_out     = 1'b0;
        if (enable && !reset && !halted_q) begin
            case (state_q)
                S_T1: begin
                    pc_output = 1'b1;
                    load_mar  = 1'b1;
                end
                S_T2: pc_increment = 1'b1;
                S_T3: begin
                    ram_output = 1'b1;
                    load_i     = 1'b1;
                end
                S_T4: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB: begin
                            ir_output = 1'b1;
                            load_mar  = 1'b1;
                        end
                        OP_OUT: begin
                            a_output = 1'b1;
                            load_out = 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_T5: begin
                    case (opcode_q)
                        OP_LDA: begin
                            ram_output = 1'b1;
                            load_a     = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            ram_output = 1'b1;
                            load_b     = 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_T6: begin
                    case (opcode_q)
                        OP_ADD: begin
                            alu_output = 1'b1;
                            load_a     = 1'b1;
                        end
                        OP_SUB: begin
                            alu_output = 1'b1;
                            load_a     = 1'b1;
                            sub        = 1'b1;
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        case (state_q)
            S_T1:    t_state = 6'b000001;
            S_T2:    t_state = 6'b000010;
            S_T3:    t_state = 6'b000100;
            S_T4:    t_state = 6'b001000;
            S_T5:    t_state = 6'b010000;
            S_T6:    t_state = 6'b100000;
            default: t_state = 6'b000000;
        endcase
    end

    assign halted = halted_q;

endmodule

// File: tb/tb_controller_sequencer.sv
// Bench for controller_sequencer: directed vector table, hand-built corner sequences, then random
// stimulus against a step-counter reference model.
module tb_controller_sequencer;

    logic       clock = 1'b0;
    logic       reset, enable;
    logic [3:0] opcode;
    logic       pc_increment, pc_output, load_mar, ram_output, load_i, ir_output;
    logic       load_a, a_output, sub, alu_output, load_b, load_out, halted;
    logic [5:0] t_state;

    controller_sequencer dut (
        .clock(clock), .reset(reset), .enable(enable), .opcode(opcode),
        .pc_increment(pc_increment), .pc_output(pc_output), .load_mar(load_mar),
        .ram_output(ram_output), .load_i(load_i), .ir_output(ir_output),
        .load_a(load_a), .a_output(a_output), .sub(sub), .alu_output(alu_output),
        .load_b(load_b), .load_out(load_out), .t_state(t_state), .halted(halted)
    );

    always #5 clock = ~clock;

    // Control word bit positions used for expectations
    localparam logic [11:0] CP = 12'h800, EP = 12'h400, LM = 12'h200, CE = 12'h100;
    localparam logic [11:0] LI = 12'h080, EI = 12'h040, LA = 12'h020, EA = 12'h010;
    localparam logic [11:0] SU = 12'h008, EU = 12'h004, LB = 12'h002, LO = 12'h001;

    int n_checks = 0;
    int n_fail   = 0;

    logic [11:0] a_ctrl;
    logic [5:0]  a_ts;
    logic        a_h;

    // Reference model: instruction step number 1..6, latched opcode, halt flag
    int         m_step = 1;
    logic [3:0] m_op   = 4'h0;
    bit         m_halt = 1'b0;

    function automatic logic [11:0] model_ctrl(bit rst, bit en, logic [3:0] op);
        if (rst || !en || m_halt) return 12'h000;
        case (m_step)
            1: return EP | LM;
            2: return CP;
            3: return CE | LI;
            4: return (op <= 4'h2) ? (EI | LM) : (op == 4'hE) ? (EA | LO) : 12'h000;
            5: return (m_op == 4'h0) ? (CE | LA) :
                      (m_op == 4'h1 || m_op == 4'h2) ? (CE | LB) : 12'h000;
            6: return (m_op == 4'h1) ? (EU | LA) : (m_op == 4'h2) ? (EU | LA | SU) : 12'h000;
            default: return 12'h000;
        endcase
    endfunction

    function automatic logic [5:0] model_ts();
        if (m_halt) return 6'b000000;
        return 6'(1 << (m_step - 1));
    endfunction

    task automatic model_edge(bit rst, bit en, logic [3:0] op);
        if (rst) begin
            m_step = 1; m_op = 4'h0; m_halt = 1'b0;
        end else if (en && !m_halt) begin
            if (m_step == 4) begin
                m_op = op;
                if (op == 4'hF) m_halt = 1'b1;
                else m_step = 5;
            end else begin
                m_step = (m_step == 6) ? 1 : m_step + 1;
            end
        end
    endtask

    task automatic check(string name, logic [11:0] act, logic [11:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One clock: drive inputs, sample at the falling edge, then let the rising edge happen
    task automatic tick(bit rst, bit en, logic [3:0] op,
                        output logic [11:0] e_ctrl, output logic [5:0] e_ts, output bit e_h);
        reset = rst; enable = en; opcode = op;
        @(negedge clock);
        a_ctrl = {pc_increment, pc_output, load_mar, ram_output, load_i, ir_output,
                  load_a, a_output, sub, alu_output, load_b, load_out};
        a_ts   = t_state;
        a_h    = halted;
        e_ctrl = model_ctrl(rst, en, op);
        e_ts   = model_ts();
        e_h    = m_halt;
        @(posedge clock);
        model_edge(rst, en, op);
        #1;
    endtask

    typedef struct {
        bit          rst;
        bit          en;
        logic [3:0]  op;
        logic [11:0] ctrl;
        logic [5:0]  ts;
        bit          h;
        bit          chk_st;
    } vec_t;

    vec_t vecs[$];

    task automatic add(bit rst, bit en, logic [3:0] op, logic [11:0] ctrl, logic [5:0] ts, bit chk);
        vec_t v;
        v.rst = rst; v.en = en; v.op = op; v.ctrl = ctrl; v.ts = ts; v.h = 1'b0; v.chk_st = chk;
        vecs.push_back(v);
    endtask

    task automatic instr(logic [3:0] op, logic [11:0] c4, logic [11:0] c5, logic [11:0] c6);
        add(0, 1, op, EP | LM, 6'b000001, 1);
        add(0, 1, op, CP,      6'b000010, 1);
        add(0, 1, op, CE | LI, 6'b000100, 1);
        add(0, 1, op, c4,      6'b001000, 1);
        add(0, 1, op, c5,      6'b010000, 1);
        add(0, 1, op, c6,      6'b100000, 1);
    endtask

    logic [11:0] e_c;
    logic [5:0]  e_t;
    bit          e_hb;
    logic [3:0]  ops[6];

    initial begin
        reset = 1'b1; enable = 1'b1; opcode = 4'h0;

        // Directed table
        add(1, 1, 4'h0, 12'h000, 6'b000000, 0);
        instr(4'h0, EI | LM, CE | LA, 12'h000);
        instr(4'h2, EI | LM, CE | LB, EU | LA | SU);
        add(0, 1, 4'hE, EP | LM, 6'b000001, 1);
        add(0, 1, 4'hE, CP,      6'b000010, 1);
        add(0, 0, 4'hE, 12'h000, 6'b000100, 1);
        add(0, 0, 4'hE, 12'h000, 6'b000100, 1);
        add(0, 0, 4'hE, 12'h000, 6'b000100, 1);
        add(0, 1, 4'hE, CE | LI, 6'b000100, 1);
        add(0, 1, 4'hE, EA | LO, 6'b001000, 1);
        add(0, 1, 4'hE, 12'h000, 6'b010000, 1);
        add(0, 1, 4'hE, 12'h000, 6'b100000, 1);
        instr(4'h5, 12'h000, 12'h000, 12'h000);
        instr(4'h1, EI | LM, CE | LB, EU | LA);
        add(0, 1, 4'h1, EP | LM, 6'b000001, 1);

        foreach (vecs[i]) begin
            tick(vecs[i].rst, vecs[i].en, vecs[i].op, e_c, e_t, e_hb);
            check($sformatf("vec%0d ctrl", i), a_ctrl, vecs[i].ctrl);
            if (vecs[i].chk_st) begin
                check($sformatf("vec%0d t_state", i), {6'h0, a_ts}, {6'h0, vecs[i].ts});
                check($sformatf("vec%0d halted", i), {11'h0, a_h}, {11'h0, vecs[i].h});
            end
        end

        // HLT: halts after T4 and ignores enable/opcode for 20 cycles, then reset recovers
        tick(1, 1, 4'hF, e_c, e_t, e_hb);
        for (int i = 0; i < 3; i++) tick(0, 1, 4'hF, e_c, e_t, e_hb);
        tick(0, 1, 4'hF, e_c, e_t, e_hb);
        check("hlt T4 ctrl", a_ctrl, 12'h000);
        check("hlt T4 t_state", {6'h0, a_ts}, 12'h008);
        for (int i = 0; i < 20; i++) begin
            tick(0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), e_c, e_t, e_hb);
            check($sformatf("halt%0d ctrl", i), a_ctrl, 12'h000);
            check($sformatf("halt%0d t_state", i), {6'h0, a_ts}, 12'h000);
            check($sformatf("halt%0d halted", i), {11'h0, a_h}, 12'h001);
        end
        tick(1, 1, 4'h0, e_c, e_t, e_hb);
        check("halt reset ctrl", a_ctrl, 12'h000);
        tick(0, 1, 4'h0, e_c, e_t, e_hb);
        check("post-halt t_state", {6'h0, a_ts}, 12'h001);
        check("post-halt halted", {11'h0, a_h}, 12'h000);
        check("post-halt ctrl", a_ctrl, EP | LM);

        // ADD captured at T4, opcode input changes to OUT during T5/T6
        tick(1, 1, 4'h1, e_c, e_t, e_hb);
        for (int i = 0; i < 4; i++) tick(0, 1, 4'h1, e_c, e_t, e_hb);
        check("capture T4 ctrl", a_ctrl, EI | LM);
        tick(0, 1, 4'hE, e_c, e_t, e_hb);
        check("capture T5 ctrl", a_ctrl, CE | LB);
        tick(0, 1, 4'hE, e_c, e_t, e_hb);
        check("capture T6 ctrl", a_ctrl, EU | LA);

        // Reset during T5 of ADD: load_b never seen, next cycle is T1
        tick(1, 1, 4'h1, e_c, e_t, e_hb);
        for (int i = 0; i < 4; i++) tick(0, 1, 4'h1, e_c, e_t, e_hb);
        tick(1, 1, 4'h1, e_c, e_t, e_hb);
        check("midreset T5 ctrl", a_ctrl, 12'h000);
        tick(0, 1, 4'h1, e_c, e_t, e_hb);
        check("midreset next t_state", {6'h0, a_ts}, 12'h001);
        check("midreset next ctrl", a_ctrl, EP | LM);
        tick(0, 1, 4'h1, e_c, e_t, e_hb);
        check("midreset T2 ctrl", a_ctrl, CP);

        // Random stimulus against the reference model
        ops = '{4'h0, 4'h1, 4'h2, 4'hE, 4'hF, 4'h7};
        tick(1, 1, 4'h0, e_c, e_t, e_hb);
        for (int i = 0; i < 1500; i++) begin
            logic [3:0] op;
            bit rst, en;
            rst = ($urandom_range(0, 24) == 0);
            en  = ($urandom_range(0, 3) != 0);
            op  = ($urandom_range(0, 1) == 0) ? ops[$urandom_range(0, 5)] : 4'($urandom_range(0, 15));
            tick(rst, en, op, e_c, e_t, e_hb);
            check($sformatf("rnd%0d ctrl", i), a_ctrl, e_c);
            check($sformatf("rnd%0d t_state", i), {6'h0, a_ts}, {6'h0, e_t});
            check($sformatf("rnd%0d halted", i), {11'h0, a_h}, {11'h0, e_hb});
            check($sformatf("rnd%0d bus drivers", i),
                  12'($countones({a_ctrl[10], a_ctrl[8], a_ctrl[6], a_ctrl[4], a_ctrl[2]}) <= 1),
                  12'h001);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/controller_sequencer.md
CONTROLLER_SEQUENCER -- requirements
Module: controller_sequencer

Interface
REQ-001 The module SHALL have exactly one clock input, named clock.
REQ-002 The module SHALL use a synchronous, active-high reset named reset.
REQ-003 Port list, one per line (name  direction  width  meaning), with clock and reset first:
 clock  input  1  rising-edge clock
 reset  input  1  synchronous, active-high reset
 enable  input  1  1 = advance T-state each cycle; 0 = freeze state
 opcode  input  4  opcode field from the instruction register
 pc_increment  output  1  program counter count enable (Cp)
 pc_output  output  1  program counter drives the bus (Ep)
 load_mar  output  1  MAR loads from the bus (Lm)
 ram_output  output  1  RAM drives the bus (CE)
 load_i  output  1  instruction register loads from the bus (Li)
 ir_output  output  1  instruction register drives the bus with its operand (Ei)
 load_a  output  1  accumulator loads from the bus (La)
 a_output  output  1  accumulator drives the bus (Ea)
 sub  output  1  ALU mode: 0 = sum, 1 = sub (Su)
 alu_output  output  1  ALU drives the bus (Eu)
 load_b  output  1  B register loads from the bus (Lb)
 load_out  output  1  output register loads from the bus (Lo)
 t_state  output  6  one-hot ring state: bit0 = T1 ... bit5 = T6; 000000 = halted
 halted  output  1  1 = HLT executed

REQ-004 All control outputs SHALL be active-high.

Function
REQ-005 The sequencer SHALL use a six-state ring counter T1->T2->...->T6->T1 plus a terminal HALT state.
REQ-006 The state SHALL advance on the rising clock edge only when enable=1; with enable=0 the state and the captured opcode hold.
REQ-007 While enable=0, all control outputs SHALL be 0.
REQ-008 Opcodes: LDA=0000, ADD=0001, SUB=0010, OUT=1110, HLT=1111; every other value SHALL execute as a NOP.
REQ-009 Fetch cycle, independent of opcode:
 T1: pc_output=1, load_mar=1.
 T2: pc_increment=1.
 T3: ram_output=1, load_i=1.
REQ-010 T4 outputs SHALL be decoded combinationally from the opcode input:
 LDA/ADD/SUB: ir_output=1, load_mar=1.
 OUT: a_output=1, load_out=1.
 HLT/NOP: none.
REQ-011 On the enabled clock edge that leaves T4, opcode SHALL be captured into an internal register (opcode_q). T5 and T6 SHALL decode opcode_q only, so later changes on the opcode input have no effect until the next T4.
REQ-012 T5 outputs:
 LDA: ram_output=1, load_a=1.
 ADD/SUB: ram_output=1, load_b=1.
 Other opcodes: none.
REQ-013 T6 outputs:
 ADD: alu_output=1, load_a=1.
 SUB: alu_output=1, load_a=1, sub=1.
 Other opcodes: none.
REQ-014 sub SHALL be 1 only in T6 of SUB.
REQ-015 In every state, at most one bus driver (pc_output, ram_output, ir_output, a_output, alu_output) SHALL be 1.
REQ-016 HLT in T4: the next enabled edge SHALL go to HALT, not T5.
REQ-017 In HALT: t_state=000000, halted=1, all control outputs are 0, and the state is left only by reset.
REQ-018 An instruction SHALL take 6 cycles, with no early return to T1 for short instructions.
REQ-019 All control outputs SHALL be combinational functions of the state, opcode/opcode_q and enable; the state, opcode_q and halted SHALL be registers.

Reset
REQ-020 reset=1 at a rising edge SHALL set state=T1, opcode_q=0000 and halted=0, overriding enable and HALT, including mid-instruction.
REQ-021 While reset=1, all control outputs SHALL be forced to 0.
REQ-022 On the first cycle after reset is released, t_state SHALL be 000001 and pc_output=1, load_mar=1.

Verification
REQ-023 Reset, then enable=1 with opcode=0000 for 6 cycles -> t_state 000001, 000010, 000100, 001000, 010000, 100000; T4 ir_output+load_mar; T5 ram_output+load_a; T6 no outputs; back to T1 on cycle 7.
REQ-024 opcode=0010 -> T5 ram_output+load_b; T6 alu_output+load_a+sub; sub=0 in every other cycle.
REQ-025 opcode=1111 -> after T4, halted=1 and t_state=000000 for 20 cycles with all outputs 0; reset=1 for one edge -> t_state=000001, halted=0.
REQ-026 enable=0 held 3 cycles during T3 -> t_state stays 000100 and load_i=0; on re-enable, T3 outputs return and the sequence continues to T4.
REQ-027 opcode=0001 captured at T4, opcode changed to 1110 during T5 -> T6 still drives alu_output+load_a with sub=0.
REQ-028 reset asserted during T5 of ADD -> next cycle is T1 and load_b is never asserted.
